// File: rtl/pc_command_receiver_if.sv
// Byte stream from the UART receiver into the PC command decoder.
interface pc_command_receiver_if;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (output rx_byte, output rx_valid);
  modport slave  (input  rx_byte, input  rx_valid);
endinterface

// File: rtl/pc_command_receiver.sv
// PC-to-FPGA command decoder: frames 0x55,CMD,DHI,DLO,[CHK],0xAA and drives TRNG control registers.
// Define CMD_CHECKSUM_EN to require the CHK byte (CMD^DHI^DLO) before the 0xAA trailer.
module pc_command_receiver #(
  parameter int   TIMEOUT_CYCLES = 1000000,
  parameter int   TO_WIDTH       = 20,
  parameter logic DEBUG_RST      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_command_receiver_if.slave    rx,
  output logic [11:0]             ROSelOverride,
  output logic                    ROSelForce,
  output logic                    debugMode,
  output logic                    restart,
  output logic                    cmdOk,
  output logic                    cmdErr,
  output logic [1:0]              errCode
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHI, S_DLO, S_CHK, S_EOF} state_t;

  localparam logic [7:0] SOF = 8'h55;
  localparam logic [7:0] EOF = 8'hAA;
  localparam logic [1:0] ERR_EOF = 2'd0, ERR_CHK = 2'd1, ERR_CMD = 2'd2, ERR_TIMEOUT = 2'd3;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  localparam int DHI_W = 8;
`else
  // Without the checksum only the low nibble of DHI ever reaches a register.
  localparam int DHI_W = 4;
`endif

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DHI_W-1:0]    dhi_q, dhi_d;
  logic [7:0]          dlo_q, dlo_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [11:0]         rosel_q, rosel_d;
  logic                force_q, force_d;
  logic                debug_q, debug_d;
  logic                restart_q, restart_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                chk_bad;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  assign chk_bad = (chk_q != (cmd_q ^ dhi_q ^ dlo_q));
`else
  assign chk_bad = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
`ifdef CMD_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    rosel_d    = rosel_q;
    force_d    = force_q;
    debug_d    = debug_q;
    restart_d  = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    to_cnt_d   = (state_q == S_IDLE || rx.rx_valid) ? '0 : to_cnt_q + TO_WIDTH'(1);

    if (rx.rx_valid) begin
      case (state_q)
        S_IDLE: if (rx.rx_byte == SOF) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = rx.rx_byte;
          state_d = S_DHI;
        end
        S_DHI: begin
          dhi_d   = rx.rx_byte[DHI_W-1:0];
          state_d = S_DLO;
        end
        S_DLO: begin
          dlo_d   = rx.rx_byte;
`ifdef CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_EOF;
`endif
        end
`ifdef CMD_CHECKSUM_EN
        S_CHK: begin
          chk_d   = rx.rx_byte;
          state_d = S_EOF;
        end
`endif
        S_EOF: begin
          state_d = S_IDLE;
          if (rx.rx_byte != EOF) begin
            err_d      = 1'b1;
            err_code_d = ERR_EOF;
          end else if (chk_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else begin
            ok_d = 1'b1;
            case (cmd_q)
              8'h01: begin
                rosel_d = {dhi_q[3:0], dlo_q};
                force_d = 1'b1;
              end
              8'h02: force_d   = 1'b0;
              8'h03: debug_d   = dlo_q[0];
              8'h04: restart_d = 1'b1;
              default: begin
                ok_d       = 1'b0;
                err_d      = 1'b1;
                err_code_d = ERR_CMD;
              end
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
      // A stalled frame is abandoned; a byte in this same cycle would have taken precedence.
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
`ifdef CMD_CHECKSUM_EN
      chk_q      <= '0;
`endif
      to_cnt_q   <= '0;
      rosel_q    <= '0;
      force_q    <= 1'b0;
      debug_q    <= DEBUG_RST;
      restart_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_EOF;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
`ifdef CMD_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
      to_cnt_q   <= to_cnt_d;
      rosel_q    <= rosel_d;
      force_q    <= force_d;
      debug_q    <= debug_d;
      restart_q  <= restart_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign ROSelOverride = rosel_q;
  assign ROSelForce    = force_q;
  assign debugMode     = debug_q;
  assign restart       = restart_q;
  assign cmdOk         = ok_q;
  assign cmdErr        = err_q;
  assign errCode       = err_code_q;

endmodule

// File: tb/tb_pc_command_receiver.sv
// Scoreboard bench for pc_command_receiver: a byte-level frame model predicts every cmdOk/cmdErr pulse.
module tb_pc_command_receiver;

  localparam int T = 40;
`ifdef CMD_CHECKSUM_EN
  localparam int PAYLOAD = 5;
  localparam bit HAS_CHK = 1'b1;
`else
  localparam int PAYLOAD = 4;
  localparam bit HAS_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_command_receiver_if rx_if();
  logic [11:0] ROSelOverride;
  logic        ROSelForce, debugMode, restart, cmdOk, cmdErr;
  logic [1:0]  errCode;

  pc_command_receiver #(.TIMEOUT_CYCLES(T), .TO_WIDTH(6), .DEBUG_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .rx(rx_if),
    .ROSelOverride(ROSelOverride), .ROSelForce(ROSelForce), .debugMode(debugMode),
    .restart(restart), .cmdOk(cmdOk), .cmdErr(cmdErr), .errCode(errCode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       ok;
    logic       err;
    logic [1:0] code;
    logic [11:0] rosel;
    logic       frc;
    logic       dbg;
    logic       rs;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: frame buffer plus the control registers it governs.
  bit          in_frame;
  int          nb;
  logic [7:0]  fb [5];
  logic [11:0] m_rosel;
  bit          m_force, m_debug;
  logic [1:0]  m_code;

  task automatic model_reset();
    in_frame = 1'b0;
    nb       = 0;
    m_rosel  = '0;
    m_force  = 1'b0;
    m_debug  = 1'b0;
    m_code   = 2'd0;
  endtask

  task automatic push(input bit ok, input bit rs, input bit err, input logic [1:0] code);
    exp_t e;
    if (err) m_code = code;
    e.ok = ok; e.err = err; e.code = m_code; e.rosel = m_rosel;
    e.frc = m_force; e.dbg = m_debug; e.rs = rs;
    exp_q.push_back(e);
  endtask

  task automatic model_frame();
    logic [15:0] d;
    d = {fb[1], fb[2]};
    if (fb[PAYLOAD-1] != 8'hAA) push(1'b0, 1'b0, 1'b1, 2'd0);
    else if (HAS_CHK && fb[3] != (fb[0] ^ fb[1] ^ fb[2])) push(1'b0, 1'b0, 1'b1, 2'd1);
    else begin
      case (fb[0])
        8'h01: begin m_rosel = d[11:0]; m_force = 1'b1; push(1'b1, 1'b0, 1'b0, 2'd0); end
        8'h02: begin m_force = 1'b0; push(1'b1, 1'b0, 1'b0, 2'd0); end
        8'h03: begin m_debug = d[0]; push(1'b1, 1'b0, 1'b0, 2'd0); end
        8'h04: push(1'b1, 1'b1, 1'b0, 2'd0);
        default: push(1'b0, 1'b0, 1'b1, 2'd2);
      endcase
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!in_frame) begin
      if (b == 8'h55) begin
        in_frame = 1'b1;
        nb       = 0;
      end
    end else begin
      fb[nb] = b;
      nb++;
      if (nb == PAYLOAD) begin
        in_frame = 1'b0;
        model_frame();
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; gap = idle cycles after the strobe.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_if.rx_byte  = b;
    rx_if.rx_valid = 1'b1;
    model_byte(b);
    if (in_frame && gap >= T) begin
      in_frame = 1'b0;
      push(1'b0, 1'b0, 1'b1, 2'd3);
    end
    @(posedge clk); #1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dhi, input logic [7:0] dlo,
                            input logic [7:0] chk_x, input logic [7:0] eof);
    send_byte(8'h55, 0);
    send_byte(cmd, 0);
    send_byte(dhi, 0);
    send_byte(dlo, 0);
    if (HAS_CHK) send_byte(cmd ^ dhi ^ dlo ^ chk_x, 0);
    send_byte(eof, 0);
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 39);
    if (r < 34)      return r % 3;
    else if (r < 36) return T - 1;
    else if (r < 38) return T;
    else             return T + 2;
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (restart) check("restart_with_ok", cmdOk, 1);
        if (cmdOk || cmdErr) begin
          if (exp_q.size() == 0) check("unexpected_pulse", {cmdOk, cmdErr}, 0);
          else begin
            e = exp_q.pop_front();
            check("pulse_ok",  cmdOk,   e.ok);
            check("pulse_err", cmdErr,  e.err);
            check("err_code",  errCode, e.code);
            check("rosel",     ROSelOverride, e.rosel);
            check("rosel_frc", ROSelForce, e.frc);
            check("debug",     debugMode, e.dbg);
            check("restart",   restart, e.rs);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] cmd, chk_x, eof;
    int r;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rosel", ROSelOverride, 0);
    check("rst_force", ROSelForce, 0);
    check("rst_debug", debugMode, 0);
    check("rst_pulses", {restart, cmdOk, cmdErr}, 0);
    check("rst_code", errCode, 0);
    rst = 1'b0;

    // SET_ROSEL with exact one-cycle latency and width.
    send_frame(8'h01, 8'h0A, 8'hBC, 8'h00, 8'hAA);
    check("ok_latency", cmdOk, 1);
    check("set_rosel", ROSelOverride, 12'hABC);
    check("set_force", ROSelForce, 1);
    @(posedge clk); #1;
    check("ok_width", cmdOk, 0);

    send_frame(8'h03, 8'h00, 8'h01, 8'h00, 8'hAA);
    check("set_debug", debugMode, 1);
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'hAA);
    check("restart_pulse", {restart, cmdOk}, 2'b11);

`ifdef CMD_CHECKSUM_EN
    send_frame(8'h01, 8'h01, 8'h23, 8'hB7, 8'hAA);
    check("chk_err", {cmdErr, errCode}, 3'b101);
    check("chk_rosel_kept", ROSelOverride, 12'hABC);
`endif
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'hAA);
    check("cmd_err", {cmdErr, errCode}, 3'b110);
    send_frame(8'h01, 8'h01, 8'h23, 8'h00, 8'h5A);
    check("eof_err", {cmdErr, errCode}, 3'b100);
    check("eof_rosel_kept", ROSelOverride, 12'hABC);

    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'hAA);
    check("release_force", {cmdOk, ROSelForce}, 2'b10);
    check("release_rosel_kept", ROSelOverride, 12'hABC);

    // Timeout boundary: T-1 idle cycles is still in time, the T-th fires.
    send_byte(8'h55, 0);
    send_byte(8'h01, T - 1);
    check("timeout_not_early", cmdErr, 0);
    in_frame = 1'b0;
    push(1'b0, 1'b0, 1'b1, 2'd3);
    @(posedge clk); #1;
    check("timeout_pulse", {cmdErr, errCode}, 3'b111);
    send_byte(8'h55, T - 1);
    send_byte(8'h01, T - 1);
    send_byte(8'h05, T - 1);
    send_byte(8'h5A, T - 1);
    if (HAS_CHK) send_byte(8'h01 ^ 8'h05 ^ 8'h5A, T - 1);
    send_byte(8'hAA, 0);
    check("slow_frame_ok", cmdOk, 1);
    check("slow_frame_rosel", ROSelOverride, 12'h55A);

    // Reset mid-frame discards the frame silently.
    send_byte(8'h55, 0);
    send_byte(8'h01, 0);
    send_byte(8'h0A, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst_outputs", {ROSelOverride, ROSelForce, debugMode, errCode}, 0);
    send_frame(8'h01, 8'h03, 8'hC4, 8'h00, 8'hAA);
    check("post_rst_rosel", ROSelOverride, 12'h3C4);

    repeat (250) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), rgap());
      r = $urandom_range(0, 9);
      cmd = (r < 8) ? 8'(r / 2 + 1) : 8'($urandom);
      chk_x = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      eof = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hAA;
      send_byte(8'h55, rgap());
      send_byte(cmd, rgap());
      send_byte(8'($urandom), rgap());
      send_byte(8'($urandom), rgap());
      if (HAS_CHK) send_byte(fb[0] ^ fb[1] ^ fb[2] ^ chk_x, rgap());
      send_byte(eof, rgap());
    end

    repeat (T + 5) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_rosel", ROSelOverride, m_rosel);
    check("final_force", ROSelForce, m_force);
    check("final_debug", debugMode, m_debug);
    check("final_code", errCode, m_code);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
